// File: rtl/pcm_packer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pcm_packer_pkg                                                  |
// | Purpose  : Shared constants and FSM state encoding for the PCM packer:     |
// |            header length, default channel/frame counts, BRAM address       |
// |            width and the packer state set.                                 |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package pcm_packer_pkg;

  localparam int HDR_LEN_DEF = 14;  // bytes reserved for the Ethernet header
  localparam int NCHAN_DEF   = 16;
  localparam int NFRAMES_DEF = 16;
  localparam int ADDR_W      = 10;  // BRAM byte address width

  // Packer state set
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_SEQ_LO     = 3'd1;
  localparam state_t ST_SEQ_HI     = 3'd2;
  localparam state_t ST_SAMPLE_LO  = 3'd3;
  localparam state_t ST_SAMPLE_HI  = 3'd4;
  localparam state_t ST_FRAME_DONE = 3'd5;
  localparam state_t ST_START      = 3'd6;
  localparam state_t ST_WAIT_TX    = 3'd7;

endpackage
`default_nettype wire

// File: rtl/pcm_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pcm_packer_if                                                   |
// | Purpose  : Bundles the PCM input, BRAM write port, transmitter handshake   |
// |            and status outputs of the packer.                               |
// | Ports    : master - packer side (drives BRAM writes, eth_start, status)    |
// |            slave  - environment side (drives PCM frames and eth_busy)      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface pcm_packer_if
  import pcm_packer_pkg::*;
#(
  parameter int NCHAN = NCHAN_DEF
) ();

  logic                  pcm_stb;
  logic [16*NCHAN-1:0]   pcm_data;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [7:0]            wr_data;
  logic                  eth_start;
  logic                  eth_busy;
  logic [15:0]           overrun_cnt;
  logic [15:0]           seq;

  modport master (
    input  pcm_stb, pcm_data, eth_busy,
    output wr_en, wr_addr, wr_data, eth_start, overrun_cnt, seq
  );

  modport slave (
    output pcm_stb, pcm_data, eth_busy,
    input  wr_en, wr_addr, wr_data, eth_start, overrun_cnt, seq
  );

endinterface
`default_nettype wire

// File: rtl/pcm_packer_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sat_counter                                                     |
// | Purpose  : Up-counter that sticks at its all-ones value.                   |
// | Ports    : clk, rst (async, active-high), inc - count enable,              |
// |            count - current value                                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pcm_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pcm_packer                                                      |
// | Purpose  : Packs NFRAMES snapshots of NCHAN 16-bit PCM samples into BRAM   |
// |            after a 2-byte sequence number (past the Ethernet header) and   |
// |            kicks the transmitter once a packet is complete.                |
// | Ports    : clk, rst (async, active-high)                                   |
// |            bus (master) - pcm_stb/pcm_data in, BRAM write port out,        |
// |            eth_start out / eth_busy in, overrun_cnt and seq status out     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pcm_packer
  import pcm_packer_pkg::*;
#(
  parameter int NCHAN   = NCHAN_DEF,
  parameter int NFRAMES = NFRAMES_DEF,
  parameter int HDR_LEN = HDR_LEN_DEF
) (
  input  logic          clk,
  input  logic          rst,
  pcm_packer_if.master  bus
);

  localparam int CH_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int FR_W = $clog2(NFRAMES + 1);
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NCHAN - 1);
  localparam logic [FR_W-1:0]   FULL_CNT = FR_W'(NFRAMES);
  localparam logic [ADDR_W-1:0] HDR_ADDR = ADDR_W'(HDR_LEN);

  state_t              r_state;
  logic [16*NCHAN-1:0] r_frame;      // snapshot; all BRAM sample bytes come from here
  logic [CH_W-1:0]     r_ch;
  logic [FR_W-1:0]     r_frames;     // frames already written into this packet
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_seq;
  logic                r_busy_seen;  // eth_busy observed high while in WAIT_TX

  logic                w_wr;
  logic                w_drop;
  logic [15:0]         w_sample;
  logic [7:0]          w_byte;

  assign w_wr = (r_state == ST_SEQ_LO)    || (r_state == ST_SEQ_HI) ||
                (r_state == ST_SAMPLE_LO) || (r_state == ST_SAMPLE_HI);

  // Only IDLE takes a frame; WAIT_TX still owns the BRAM, so a strobe there
  // is lost just like one arriving mid-packing.
  assign w_drop = bus.pcm_stb && (r_state != ST_IDLE);

  // Byte-select mux: current channel, low byte first.
  assign w_sample = r_frame[int'(r_ch)*16 +: 16];

  always_comb begin
    w_byte = 8'h00;
    case (r_state)
      ST_SEQ_LO:    w_byte = r_seq[7:0];
      ST_SEQ_HI:    w_byte = r_seq[15:8];
      ST_SAMPLE_LO: w_byte = w_sample[7:0];
      ST_SAMPLE_HI: w_byte = w_sample[15:8];
      default:      w_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_frame     <= '0;
      r_ch        <= '0;
      r_frames    <= '0;
      r_addr      <= HDR_ADDR;
      r_seq       <= '0;
      r_busy_seen <= 1'b0;
    end else begin
      if (w_wr) begin
        r_addr <= r_addr + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.pcm_stb) begin
            r_frame <= bus.pcm_data;
            r_ch    <= '0;
            // Sequence bytes lead only the first frame of a packet.
            r_state <= (r_frames == '0) ? ST_SEQ_LO : ST_SAMPLE_LO;
          end
        end
        ST_SEQ_LO:    r_state <= ST_SEQ_HI;
        ST_SEQ_HI:    r_state <= ST_SAMPLE_LO;
        ST_SAMPLE_LO: r_state <= ST_SAMPLE_HI;
        ST_SAMPLE_HI: begin
          if (r_ch == LAST_CH) begin
            r_frames <= r_frames + 1'b1;
            r_state  <= ST_FRAME_DONE;
          end else begin
            r_ch    <= r_ch + 1'b1;
            r_state <= ST_SAMPLE_LO;
          end
        end
        ST_FRAME_DONE: r_state <= (r_frames == FULL_CNT) ? ST_START : ST_IDLE;
        ST_START: begin
          r_frames    <= '0;
          r_addr      <= HDR_ADDR;
          r_busy_seen <= 1'b0;
          r_state     <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          // Release the BRAM only after a full busy high-then-low cycle.
          if (bus.eth_busy) begin
            r_busy_seen <= 1'b1;
          end else if (r_busy_seen) begin
            r_busy_seen <= 1'b0;
            r_seq       <= r_seq + 16'd1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(
    .WIDTH (16)
  ) u_overrun (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_drop),
    .count (bus.overrun_cnt)
  );

  assign bus.wr_en     = w_wr;
  assign bus.wr_addr   = r_addr;
  assign bus.wr_data   = w_byte;
  assign bus.eth_start = (r_state == ST_START);
  assign bus.seq       = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_pcm_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pcm_packer                                                   |
// | Purpose  : Randomised self-checking bench for pcm_packer. A packet-level   |
// |            reference model predicts every BRAM write (cycle, address,      |
// |            byte), the eth_start timing, seq and overrun_cnt.               |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pcm_packer;
  import pcm_packer_pkg::*;

  localparam int NCH         = 16;
  localparam int NFR         = 16;
  localparam int HDR         = 14;
  localparam int FRAME_BYTES = 2 * NCH;
  localparam int NEVER       = 32'h7fff_ffff;

  typedef struct {
    int c;
    int a;
    int d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pcm_packer_if #(.NCHAN(NCH)) bus ();

  pcm_packer #(
    .NCHAN   (NCH),
    .NFRAMES (NFR),
    .HDR_LEN (HDR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  wr_t obs_q[$];
  wr_t exp_q[$];
  int  m_seq      = 0;
  int  m_ovr      = 0;
  int  m_frames   = 0;
  int  ready_cyc  = 0;   // first cycle in which a strobe is taken
  int  m_last_wr  = 0;
  int  start_cnt  = 0;
  int  start_cyc  = 0;

  function automatic wr_t mk_wr(input int c, input int a, input int d);
    wr_t w;
    w.c = c;
    w.a = a;
    w.d = d;
    return w;
  endfunction

  // Observe BRAM writes and eth_start mid-cycle.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) obs_q.push_back(mk_wr(cyc, int'(bus.wr_addr), int'(bus.wr_data)));
    if (bus.eth_start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A strobe seen in cycle k. Accepted frames occupy: 2 seq cycles (first frame
  // only), 2*NCH write cycles, one wrap-up cycle; a full packet blocks until tx.
  function automatic void model_stb(input int k, input logic [16*NCH-1:0] d);
    int lat;
    int base;
    if (k >= ready_cyc) begin
      lat = 1;
      if (m_frames == 0) begin
        exp_q.push_back(mk_wr(k + 1, HDR,     m_seq & 8'hFF));
        exp_q.push_back(mk_wr(k + 2, HDR + 1, (m_seq >> 8) & 8'hFF));
        lat = 3;
      end
      base = HDR + 2 + m_frames * FRAME_BYTES;
      for (int i = 0; i < FRAME_BYTES; i++)
        exp_q.push_back(mk_wr(k + lat + i, base + i, int'(d[16*(i/2) + 8*(i%2) +: 8])));
      m_frames++;
      m_last_wr = k + lat + FRAME_BYTES - 1;
      ready_cyc = (m_frames == NFR) ? NEVER : k + lat + FRAME_BYTES + 1;
    end else begin
      m_ovr = (m_ovr < 16'hFFFF) ? m_ovr + 1 : 16'hFFFF;
    end
  endfunction

  task automatic send_frame(input int gap, input bit directed);
    logic [16*NCH-1:0] d;
    repeat (gap) step();
    for (int c = 0; c < NCH; c++)
      d[16*c +: 16] = directed ? 16'(16'h0100 + c) : 16'($urandom);
    bus.pcm_data = d;
    bus.pcm_stb  = 1'b1;
    model_stb(cyc, d);
    step();
    bus.pcm_stb = 1'b0;
    for (int c = 0; c < NCH; c++) bus.pcm_data[16*c +: 16] = 16'($urandom);
  endtask

  task automatic fill_packet();
    int iter;
    iter = 0;
    while (m_frames < NFR && iter < 400) begin
      send_frame($urandom_range(1, 45), 1'b0);
      iter++;
    end
    check_val("frames_accepted", m_frames, NFR);
  endtask

  task automatic compare_writes();
    int n;
    check_val("num_writes", obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_val("wr_cycle", obs_q[i].c, exp_q[i].c);
      check_val("wr_addr",  obs_q[i].a, exp_q[i].a);
      check_val("wr_data",  obs_q[i].d, exp_q[i].d);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Returns at the negedge of the eth_start cycle (or after the bound).
  task automatic wait_start(output bit seen);
    int t;
    seen = 1'b0;
    t = 0;
    while (!seen && t < 200) begin
      @(negedge clk);
      t++;
      if (bus.eth_start === 1'b1) seen = 1'b1;
    end
    check_val("eth_start_seen", seen, 1);
    if (seen) check_val("eth_start_cycle", cyc, m_last_wr + 2);
  endtask

  task automatic finish_packet(input int busy_len, input bit stb_on_start, input int npulse);
    bit seen;
    int gap;
    wait_start(seen);
    if (seen && stb_on_start) begin
      bus.pcm_stb = 1'b1;          // sampled at the end of the eth_start cycle
      model_stb(cyc, bus.pcm_data);
    end
    step();
    bus.pcm_stb = 1'b0;
    repeat ($urandom_range(1, 5)) step();
    bus.eth_busy = 1'b1;
    gap = busy_len / (npulse + 1);
    for (int i = 0; i < busy_len; i++) begin
      if (npulse > 0 && gap > 0 && i > 0 && (i % gap) == 0 && (i / gap) <= npulse) begin
        bus.pcm_stb = 1'b1;
        model_stb(cyc, bus.pcm_data);
      end else begin
        bus.pcm_stb = 1'b0;
      end
      step();
    end
    bus.pcm_stb  = 1'b0;
    bus.eth_busy = 1'b0;
    ready_cyc = cyc + 1;
    m_seq     = (m_seq + 1) & 16'hFFFF;
    m_frames  = 0;
    step();
    check_val("eth_start_pulses", start_cnt, 1);
    check_val("seq", bus.seq, m_seq);
    check_val("overrun_cnt", bus.overrun_cnt, m_ovr);
    compare_writes();
    start_cnt = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int ovr_before;
    bus.pcm_stb  = 1'b0;
    bus.pcm_data = '0;
    bus.eth_busy = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_wr_en",     bus.wr_en, 0);
    check_val("rst_eth_start", bus.eth_start, 0);
    check_val("rst_wr_addr",   bus.wr_addr, HDR);
    check_val("rst_wr_data",   bus.wr_data, 0);
    check_val("rst_seq",       bus.seq, 0);
    check_val("rst_overrun",   bus.overrun_cnt, 0);
    rst = 1'b0;

    // Packet 0: directed first frame, then a strobe 10 cycles later (dropped).
    send_frame(2, 1'b1);
    send_frame(9, 1'b0);
    repeat (40) step();
    check_val("ovr_after_early_stb", bus.overrun_cnt, 1);
    check_val("no_start_single", start_cnt, 0);
    if (obs_q.size() >= 34) begin
      check_val("dir_a14", obs_q[0].d, 8'h00);
      check_val("dir_a15", obs_q[1].d, 8'h00);
      check_val("dir_a16", obs_q[2].d, 8'h00);
      check_val("dir_a17", obs_q[3].d, 8'h01);
      check_val("dir_last_addr", obs_q[33].a, 47);
      check_val("dir_last_data", obs_q[33].d, 8'h01);
    end else begin
      check_val("dir_writes", obs_q.size(), 34);
    end
    fill_packet();
    finish_packet(12, 1'b1, 2);

    // Packet 1: long transmitter hold-off with five dropped strobes.
    fill_packet();
    ovr_before = m_ovr;
    finish_packet(2000, 1'b0, 5);
    check_val("holdoff_drops", m_ovr - ovr_before, 5);

    // Packet 2: carries seq = 2.
    fill_packet();
    finish_packet($urandom_range(3, 40), 1'b1, $urandom_range(0, 3));

    // Reset in the middle of the 8th frame of a packet.
    while (m_frames < 7) send_frame($urandom_range(36, 45), 1'b0);
    send_frame(40, 1'b0);
    repeat (5) step();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_val("mid_rst_wr_en",     bus.wr_en, 0);
    check_val("mid_rst_eth_start", bus.eth_start, 0);
    check_val("mid_rst_wr_addr",   bus.wr_addr, HDR);
    check_val("mid_rst_wr_data",   bus.wr_data, 0);
    check_val("mid_rst_seq",       bus.seq, 0);
    check_val("mid_rst_overrun",   bus.overrun_cnt, 0);
    check_val("mid_rst_no_start",  start_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
    m_seq = 0;
    m_ovr = 0;
    m_frames = 0;
    ready_cyc = 0;
    start_cnt = 0;
    fill_packet();
    finish_packet($urandom_range(3, 40), 1'b0, 1);

    // Saturation: a full packet whose transmitter never starts, strobe held high.
    fill_packet();
    wait_start(seen);
    step();
    bus.pcm_stb = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      model_stb(cyc, bus.pcm_data);
      step();
    end
    bus.pcm_stb = 1'b0;
    step();
    check_val("overrun_saturated", bus.overrun_cnt, 16'hFFFF);
    check_val("model_saturated", m_ovr, 16'hFFFF);
    check_val("sat_start_pulses", start_cnt, 1);
    compare_writes();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
